// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register peripheral: FSM states, register map
// addresses and frame geometry.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  localparam int         FRAME_BITS = 16;
  localparam logic [4:0] CNT_FULL   = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT    = 5'(FRAME_BITS + 1);

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for an asynchronous input, followed by a history flop
// that yields single-cycle rise/fall pulses on the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // previous stage's old value; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  q_o & ~hist_q;
  assign fall_o = ~q_o &  hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register bank: 16-bit frames {wr, addr[6:0], data[7:0]}
// commit one byte into one of five output-enable / PWM control registers.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done
);

  logic sclk_rise, copi_s, ncs_s, ncs_rise, ncs_fall;
  logic unused_sclk_s, unused_sclk_fall, unused_copi_rise, unused_copi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .q_o(unused_sclk_s), .rise_o(sclk_rise), .fall_o(unused_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi),
    .q_o(copi_s), .rise_o(unused_copi_rise), .fall_o(unused_copi_fall)
  );

  // Chip select idles high, so its chain resets high to avoid a phantom edge.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs),
    .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  state_t      state_q;
  logic [15:0] shift_q;
  logic [4:0]  cnt_q;
  logic        pend_q;
  logic        txn_done_q;
  logic [7:0]  out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;

  logic       wr_ok;
  logic [6:0] frame_addr;
  assign frame_addr = shift_q[14:8];
  assign wr_ok      = (cnt_q == CNT_FULL) && shift_q[15] && (frame_addr <= MAX_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      txn_done_q <= 1'b0;
      out_lo_q   <= '0;
      out_hi_q   <= '0;
      pwm_lo_q   <= '0;
      pwm_hi_q   <= '0;
      duty_q     <= '0;
    end else begin
      txn_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pend_q <= 1'b0;
          // A select that dropped during COMMIT is remembered in pend_q.
          if (ncs_fall || pend_q) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise && !ncs_s) begin
            shift_q <= {shift_q[14:0], copi_s};
            cnt_q   <= (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 5'd1;
          end
          if (ncs_rise) state_q <= COMMIT;
        end
        COMMIT: begin
          pend_q  <= ncs_fall;
          state_q <= IDLE;
          if (wr_ok) begin
            txn_done_q <= 1'b1;
            case (frame_addr)
              ADDR_EN_OUT_7_0:  out_lo_q <= shift_q[7:0];
              ADDR_EN_OUT_15_8: out_hi_q <= shift_q[7:0];
              ADDR_EN_PWM_7_0:  pwm_lo_q <= shift_q[7:0];
              ADDR_EN_PWM_15_8: pwm_hi_q <= shift_q[7:0];
              ADDR_PWM_DUTY:    duty_q   <= shift_q[7:0];
              default: ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign txn_done        = txn_done_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral: directed frames plus random
// frames, compared against a register-map model kept in the bench.
module tb_spi_reg_peripheral;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       txn_done;

  spi_reg_peripheral dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .txn_done(txn_done)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         pulse_cnt = 0;
  logic [7:0] exp_regs [5];

  always @(negedge clk) if (txn_done === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dut_reg(input int idx);
    case (idx)
      0:       return en_reg_out_7_0;
      1:       return en_reg_out_15_8;
      2:       return en_reg_pwm_7_0;
      3:       return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s reg%0d", tag, i), {24'd0, dut_reg(i)}, {24'd0, exp_regs[i]});
  endtask

  // Sends the top nsend bits of an nbits-long frame at sclk = clk/10; raises
  // ncs only when the whole frame has been sent.
  task automatic drive_frame(input logic [16:0] bits, input int nbits, input int nsend);
    @(negedge clk);
    ncs = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = nbits - 1; i >= nbits - nsend; i--) begin
      copi = bits[i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    if (nsend == nbits) begin
      repeat (5) @(negedge clk);
      ncs = 1'b1;
    end
  endtask

  task automatic frame_checked(input string tag, input logic [16:0] bits, input int nbits);
    int  p0, hit_edge;
    bit  ok;
    ok = (nbits == 16) && bits[15] && (bits[14:8] <= 7'h04);
    p0 = pulse_cnt;
    hit_edge = 0;
    drive_frame(bits, nbits, nbits);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (txn_done === 1'b1 && hit_edge == 0) hit_edge = k;
    end
    if (ok) exp_regs[int'(bits[14:8])] = bits[7:0];
    check({tag, " txn_edge"}, hit_edge, ok ? 4 : 0);
    check({tag, " txn_pulses"}, pulse_cnt - p0, ok ? 1 : 0);
    check_regs(tag);
  endtask

  initial begin
    logic [16:0] f;
    int          nb, r, p0;

    rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset txn_done", txn_done, 0);
    check_regs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    frame_checked("wr00_F0", 17'h080F0, 16);
    frame_checked("wr04_80", 17'h08480, 16);
    frame_checked("wr02_01", 17'h08201, 16);
    frame_checked("read0155", 17'h00155, 16);
    frame_checked("wr30_AA", 17'h0B0AA, 16);
    frame_checked("short15", 17'h081AA >> 1, 15);
    frame_checked("long17", {16'h81AA, 1'b1}, 17);
    frame_checked("wr01_0F", 17'h0810F, 16);

    // Reset arrives after bit 9 of a write of 0xFF to address 0x03.
    drive_frame(17'h083FF, 16, 9);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("midreset txn_done", txn_done, 0);
    check_regs("midreset");
    ncs = 1'b1; sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    frame_checked("post_reset wr03_FF", 17'h083FF, 16);

    // Stray sclk activity with chip select high must do nothing.
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      copi = 1'($urandom);
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    check("stray txn_pulses", pulse_cnt - p0, 0);
    check_regs("stray");

    // Back-to-back frames with only two clocks of ncs-high time between them.
    p0 = pulse_cnt;
    drive_frame(17'h08111, 16, 16);
    @(negedge clk);
    drive_frame(17'h08422, 16, 16);
    repeat (10) @(negedge clk);
    exp_regs[1] = 8'h11;
    exp_regs[4] = 8'h22;
    check("b2b txn_pulses", pulse_cnt - p0, 2);
    check_regs("b2b");

    for (int n = 0; n < 14; n++) begin
      f  = 17'($urandom);
      nb = 16;
      r  = int'($urandom_range(0, 9));
      if (r < 6) begin
        f[15] = 1'b1; f[14:8] = 7'($urandom_range(0, 4));
      end else if (r == 6) begin
        f[15] = 1'b0;
      end else if (r == 7) begin
        f[15] = 1'b1; f[14:8] = 7'($urandom_range(5, 127));
      end else begin
        nb = (r == 8) ? 15 : 17;
      end
      frame_checked($sformatf("rand%0d", n), f, nb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_reg_peripheral.md
SPI_REG_PERIPHERAL -- requirements
Module: spi_reg_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop count of each input synchronizer.
REQ-002 Parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 sclk  input  1  SPI serial clock from ui_in[0]; asynchronous to clk.
REQ-006 copi  input  1  SPI controller-out data from ui_in[1]; asynchronous to clk.
REQ-007 ncs  input  1  SPI chip select from ui_in[2]; active-low; asynchronous to clk.
REQ-008 en_reg_out_7_0  output  8  register 0x00: output enables for uo_out[7:0].
REQ-009 en_reg_out_15_8  output  8  register 0x01: output enables for uio_out[7:0].
REQ-010 en_reg_pwm_7_0  output  8  register 0x02: PWM mode select for uo_out[7:0].
REQ-011 en_reg_pwm_15_8  output  8  register 0x03: PWM mode select for uio_out[7:0].
REQ-012 pwm_duty_cycle  output  8  register 0x04: duty cycle shared by all PWM channels.
REQ-013 txn_done  output  1  one-clk pulse on every register commit.

Function
REQ-014 sclk, copi and ncs SHALL each pass through a SYNC_STAGES flip-flop synchronizer followed by one history flop used for edge detection.
REQ-015 The block SHALL operate in SPI mode 0: copi is sampled on each synchronized sclk rising edge while synchronized ncs is low, MSB first.
REQ-016 Frame format, 16 bits: bit15 = R/W (1 = write), bits14:8 = 7-bit address, bits7:0 = data.
REQ-017 FSM states: IDLE, SHIFT, COMMIT.
REQ-018 IDLE -> SHIFT on a synchronized ncs falling edge; on entry the shift register and bit counter SHALL clear.
REQ-019 SHIFT: each sampled bit shifts into bit 0 of a 16-bit register; the 5-bit counter increments and saturates at 17.
REQ-020 SHIFT -> COMMIT on a synchronized ncs rising edge.
REQ-021 COMMIT SHALL write the data byte to the addressed register only if count == 16, R/W == 1, and address <= MAX_ADDR; otherwise no register changes. In every case COMMIT -> IDLE after one cycle.
REQ-022 txn_done SHALL be high for exactly the one COMMIT cycle of a committed write; it is low for rejected frames.
REQ-023 Latency: with SYNC_STAGES = 2, the register value and txn_done SHALL be visible after the 4th clk rising edge following the ncs pin rising edge.
REQ-024 Frame rejection: reads (R/W = 0), short frames (< 16 bits), long frames (> 16 bits) and addresses 0x05–0x7F SHALL be silently discarded.
REQ-025 sclk edges while ncs is high SHALL be ignored.
REQ-026 An ncs falling edge in COMMIT SHALL be honoured on the next IDLE cycle, so back-to-back frames are not lost.
REQ-027 The supported sclk frequency is at most clk/8.
REQ-028 Registers not addressed by a commit SHALL hold their values.

Reset
REQ-029 While rst_n is low, all five registers, txn_done, the shift register, the counter and all synchronizer flops SHALL be 0, and the FSM SHALL be in IDLE. ncs synchronizer flops SHALL instead reset to 1 so that no false edge is detected.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no register written; after release, the next complete frame SHALL be accepted normally.

Structure
REQ-031 The shared package spi_reg_pkg SHALL hold the FSM state enum, the ADDR_EN_OUT_7_0..ADDR_PWM_DUTY constants (0x00–0x04), and the FRAME_BITS = 16 constant.
REQ-032 The block SHALL use one sub-module, sync_edge: an N-stage synchronizer with a parameterized reset value and rise/fall pulse outputs, instantiated three times.

Verification
REQ-033 Scenario: reset, then write frame 0x8000|0xF0 (address 0x00, data 0xF0) at sclk = clk/10 -> en_reg_out_7_0 = 0xF0; txn_done pulses once; all other registers are 0.
REQ-034 Scenario: write addr 0x04 data 0x80, then addr 0x02 data 0x01 -> pwm_duty_cycle = 0x80 and en_reg_pwm_7_0 = 0x01; the other registers are unchanged.
REQ-035 Scenario: read frame 0x0155 and write frame to addr 0x30 (0xB0AA) -> all registers unchanged; txn_done stays low.
REQ-036 Scenario: 15-bit and 17-bit frames targeting addr 0x01 -> en_reg_out_15_8 unchanged; a following valid 16-bit write of 0x0F lands as 0x0F.
REQ-037 Scenario: rst_n asserted after bit 9 of a write of 0xFF to addr 0x03 -> en_reg_pwm_15_8 = 0 after reset; a subsequent full frame writes correctly.
REQ-038 Scenario: two frames separated by 2 clk of ncs-high time, and sclk toggling while ncs is high -> both frames are committed; the stray sclk toggles have no effect.
